// File: rtl/vc_control_pkg.sv
// Shared types for the victim-cache controller: FSM state encoding and cache geometry.
package vc_control_pkg;
  localparam int VC_WAYS  = 8;
  localparam int VC_IDX_W = $clog2(VC_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP_R,
    HIT_RD,
    MISS_RD,
    LOOKUP_W,
    WB,
    INSERT
  } vc_state_t;
endpackage

// File: rtl/vc_control_way_select.sv
// Combinational way selection for the victim cache: qualified hit, first free way, and the
// target way for an incoming eviction (hit, else lowest free, else LRU). Lowest index wins.
module vc_way_select
  import vc_control_pkg::*;
#(
  parameter int WAYS  = VC_WAYS,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  way_hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [IDX_W-1:0] lru_way,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             free,
  output logic [IDX_W-1:0] free_idx,
  output logic [IDX_W-1:0] target
);

  logic [WAYS-1:0] hit_vec;

  always_comb begin
    hit_vec  = way_hit & valid;
    hit      = |hit_vec;
    free     = ~&valid;
    hit_idx  = '0;
    free_idx = '0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
      if (!valid[i])  free_idx = IDX_W'(i);
    end
    if (hit)       target = hit_idx;
    else if (free) target = free_idx;
    else           target = lru_way;
  end

endmodule

// File: rtl/vc_control.sv
// Victim-cache controller: serves L2 read misses, absorbs L2 evictions, writes back dirty victims.
// Optional hit/miss statistics counters are built when VC_STATS_EN is defined.
//
// state    | meaning
// IDLE     | wait for an L2 request (eviction has priority over read)
// LOOKUP_R | compare read address against the VC
// HIT_RD   | return VC line to L2 and drop it from the VC
// MISS_RD  | fetch line from pmem on behalf of L2
// LOOKUP_W | choose the target way for an eviction
// WB       | write the dirty victim back to pmem
// INSERT   | load the evicted L2 line into the target way
module vc_control
  import vc_control_pkg::*;
#(
  parameter int WAYS  = VC_WAYS,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l2_read,
  input  logic             l2_write,
  input  logic             l2_dirty,
  output logic             l2_resp,
  output logic             l2_rdata_sel,
  input  logic [WAYS-1:0]  way_hit,
  input  logic [IDX_W-1:0] lru_way,
  output logic [IDX_W-1:0] vc_index,
  output logic             load_vc,
  output logic             load_lru,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp
`ifdef VC_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  vc_state_t        state_q, state_d;
  logic [WAYS-1:0]  valid_q, valid_d;
  logic [WAYS-1:0]  dirty_q, dirty_d;
  logic [IDX_W-1:0] vc_index_q, vc_index_d;
  logic             lkp_hit_q, lkp_hit_d;

  logic             sel_hit;
  logic [IDX_W-1:0] sel_hit_idx;
  logic             sel_free;
  logic [IDX_W-1:0] sel_free_idx;
  logic [IDX_W-1:0] sel_target;

  vc_way_select #(.WAYS(WAYS), .IDX_W(IDX_W)) u_way_select (
    .way_hit  (way_hit),
    .valid    (valid_q),
    .lru_way  (lru_way),
    .hit      (sel_hit),
    .hit_idx  (sel_hit_idx),
    .free     (sel_free),
    .free_idx (sel_free_idx),
    .target   (sel_target)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    vc_index_d   = vc_index_q;
    lkp_hit_d    = lkp_hit_q;
    l2_resp      = 1'b0;
    l2_rdata_sel = 1'b0;
    load_vc      = 1'b0;
    load_lru     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (l2_write)     state_d = LOOKUP_W;
        else if (l2_read) state_d = LOOKUP_R;
      end
      LOOKUP_R: begin
        if (sel_hit) begin
          vc_index_d = sel_hit_idx;
          state_d    = HIT_RD;
        end else begin
          state_d = MISS_RD;
        end
      end
      HIT_RD: begin
        // Exclusive swap: L2 takes ownership, so the way is freed.
        l2_resp              = 1'b1;
        valid_d[vc_index_q]  = 1'b0;
        dirty_d[vc_index_q]  = 1'b0;
        state_d              = IDLE;
      end
      MISS_RD: begin
        if (pmem_resp) begin
          l2_resp      = 1'b1;
          l2_rdata_sel = 1'b1;
          state_d      = IDLE;
        end else begin
          pmem_read = 1'b1;
        end
      end
      LOOKUP_W: begin
        vc_index_d = sel_target;
        lkp_hit_d  = sel_hit;
        // Target is only a valid non-hit way when the VC is full (LRU victim).
        if (!sel_hit && !sel_free && dirty_q[sel_target]) state_d = WB;
        else                                                state_d = INSERT;
      end
      WB: begin
        if (pmem_resp) state_d = INSERT;
        else           pmem_write = 1'b1;
      end
      INSERT: begin
        load_vc             = 1'b1;
        load_lru            = 1'b1;
        l2_resp             = 1'b1;
        valid_d[vc_index_q] = 1'b1;
        dirty_d[vc_index_q] = l2_dirty | (lkp_hit_q & dirty_q[vc_index_q]);
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vc_index = vc_index_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      vc_index_q <= '0;
      lkp_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      vc_index_q <= vc_index_d;
      lkp_hit_q  <= lkp_hit_d;
    end
  end

`ifdef VC_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP_R) begin
      if (sel_hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q inside {LOOKUP_R, LOOKUP_W}) |-> $onehot0(way_hit & valid_q));

  a_free_target: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == LOOKUP_W && !sel_hit && sel_free) |-> (sel_target == sel_free_idx));

endmodule
